// File: rtl/instr_halfword_assembler.sv
// instr_halfword_assembler
// Collects 16-bit halfwords from the fetch buffer into one 1/2/3-halfword
// instruction. The instruction length comes from the group field of hw0.
// The assembled {hw0, hw1, hw2} word is held for the decoder behind a
// valid/ready handshake.
module instr_halfword_assembler #(
  parameter int HW_WIDTH   = 16,
  parameter int ADDR_WIDTH = 32,
  // Group field position inside hw0: the two most significant bits.
  parameter int GROUP_HI   = HW_WIDTH - 1,
  parameter int GROUP_LO   = HW_WIDTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HW_WIDTH-1:0]     in_hw,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*HW_WIDTH-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [1:0]              out_len
);

  typedef enum logic [1:0] {
    S_HW0,
    S_HW1,
    S_HW2,
    S_FULL
  } state_t;

  state_t                  state_q, state_d;
  logic [HW_WIDTH-1:0]     hw0_q, hw1_q, hw2_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [1:0]              len_q;
  logic                    valid_q;

  logic                    accept;
  logic                    cap_hw0, cap_hw1, cap_hw2;
  logic [1:0]              new_len;

  // Instruction length in halfwords, decoded from the group field of hw0.
  function automatic logic [1:0] len_of(input logic [HW_WIDTH-1:0] hw);
    logic [GROUP_HI-GROUP_LO:0] group;
    group = hw[GROUP_HI:GROUP_LO];
    case (group)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      2'd2:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Handshake: only a held instruction that the decoder refuses blocks input.
  assign in_ready = (state_q != S_FULL) || out_ready;
  assign accept   = in_valid && in_ready;
  assign new_len  = len_of(in_hw);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    if (rst) state_q <= S_HW0;
    else     state_q <= state_d;
  end

  // Next-state and halfword capture enables.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    state_d = state_q;
    cap_hw0 = 1'b0;
    cap_hw1 = 1'b0;
    cap_hw2 = 1'b0;

    unique case (state_q)
      S_HW0: begin
        if (accept) begin
          cap_hw0 = 1'b1;
          state_d = (new_len == 2'd1) ? S_FULL : S_HW1;
        end
      end
      S_HW1: begin
        if (accept) begin
          cap_hw1 = 1'b1;
          state_d = (len_q == 2'd2) ? S_FULL : S_HW2;
        end
      end
      S_HW2: begin
        if (accept) begin
          cap_hw2 = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        // On handoff, a halfword accepted in the same cycle starts the next
        // instruction immediately, so back-to-back instructions have no bubble.
        if (out_ready) begin
          if (accept) begin
            cap_hw0 = 1'b1;
            state_d = (new_len == 2'd1) ? S_FULL : S_HW1;
          end else begin
            state_d = S_HW0;
          end
        end
      end
      default: state_d = S_HW0;
    endcase

    // Branch redirect wins over any accept or handoff in the same cycle;
    // the halfword presented now is dropped.
    if (flush) begin
      state_d = S_HW0;
      cap_hw0 = 1'b0;
      cap_hw1 = 1'b0;
      cap_hw2 = 1'b0;
    end
  end

  // Halfword, PC and length registers plus the registered valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw0_q   <= '0;
      hw1_q   <= '0;
      hw2_q   <= '0;
      pc_q    <= '0;
      len_q   <= 2'd1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_d == S_FULL);
      if (flush) begin
        hw0_q <= '0;
        hw1_q <= '0;
        hw2_q <= '0;
      end else if (cap_hw0) begin
        // A new hw0 clears the tail so shorter instructions read zero there.
        hw0_q <= in_hw;
        hw1_q <= '0;
        hw2_q <= '0;
        pc_q  <= in_pc;
        len_q <= new_len;
      end else if (cap_hw1) begin
        hw1_q <= in_hw;
      end else if (cap_hw2) begin
        hw2_q <= in_hw;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_instr = {hw0_q, hw1_q, hw2_q};
  assign out_pc    = pc_q;
  assign out_len   = len_q;

endmodule
